// File: rtl/montgomery_convert_in.sv
// Montgomery-domain entry conversion: T = A * 2^LOGQ mod Q, with Q = {qH, M'b0} | 1.
// Iterative shift-and-conditional-subtract engine, STEP bits per cycle, valid/ready on both sides.
module montgomery_convert_in #(
  parameter int LOGQ  = 32,
  parameter int LOGQH = 15,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGQ-1:0]  A,
  input  logic [LOGQH-1:0] qH,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  T,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and data is held stable while valid && !ready.

  localparam int M     = LOGQ - LOGQH;
  localparam int NITER = LOGQ / STEP;
  localparam int CW    = $clog2(NITER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [LOGQ-1:0]  r;
  logic [LOGQH-1:0] qh_r;
  logic [CW-1:0]    cnt;

  logic [LOGQ-1:0]  q_full;
  logic [LOGQ-1:0]  pre_next;
  logic [LOGQ+1:0]  s_w;
  logic [LOGQ+1:0]  q1;
  logic [LOGQ+1:0]  q2;
  logic [LOGQ+1:0]  q3;
  logic [LOGQ-1:0]  iter_next;

  assign q_full = {qh_r, {M{1'b0}}} | {{(LOGQ-1){1'b0}}, 1'b1};

  // A < 2^LOGQ < 2Q, so a single conditional subtraction brings r into [0, Q).
  assign pre_next = (r >= q_full) ? (r - q_full) : r;

  // r < Q keeps s below 2^STEP * Q, so the largest k with s >= k*Q is at most 2^STEP - 1.
  always_comb begin
    s_w       = {2'b00, r} << STEP;
    q1        = {2'b00, q_full};
    q2        = q1 << 1;
    q3        = q1 + q2;
    iter_next = s_w[LOGQ-1:0];
    if (STEP == 2 && s_w >= q3)
      iter_next = LOGQ'(s_w - q3);
    else if (STEP == 2 && s_w >= q2)
      iter_next = LOGQ'(s_w - q2);
    else if (s_w >= q1)
      iter_next = LOGQ'(s_w - q1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      r     <= '0;
      qh_r  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            r     <= A;
            qh_r  <= qH;
            state <= S_PRE;
          end
        end
        S_PRE: begin
          r     <= pre_next;
          cnt   <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          r   <= iter_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NITER - 1))
            state <= S_DONE;
        end
        default: begin
          if (out_ready)
            state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign T         = r;
  assign dbg_state = state;

endmodule

// File: tb/tb_montgomery_convert_in.sv
// Directed bench for montgomery_convert_in: one instance with STEP=1 and one with STEP=2,
// Q = 0x80000001 for the directed vectors, plus a short randomised run against a software model.
module tb_montgomery_convert_in;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_d[2];
  logic        in_valid_d[2];
  logic        out_ready_d[2];
  logic [31:0] a_d[2];
  logic [14:0] qh_d[2];
  logic        in_ready_w[2];
  logic        out_valid_w[2];
  logic [31:0] t_w[2];
  logic [1:0]  st_w[2];

  int checks = 0;
  int passed = 0;

  montgomery_convert_in #(.LOGQ(32), .LOGQH(15), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n_d[0]), .in_valid(in_valid_d[0]), .in_ready(in_ready_w[0]),
    .A(a_d[0]), .qH(qh_d[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready_d[0]),
    .T(t_w[0]), .dbg_state(st_w[0])
  );

  montgomery_convert_in #(.LOGQ(32), .LOGQH(15), .STEP(2)) u_s2 (
    .clk(clk), .rst_n(rst_n_d[1]), .in_valid(in_valid_d[1]), .in_ready(in_ready_w[1]),
    .A(a_d[1]), .qH(qh_d[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready_d[1]),
    .T(t_w[1]), .dbg_state(st_w[1])
  );

  task automatic chk(input string tag, input int s, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s step=%0d observed=0x%0h expected=0x%0h", tag, s + 1, obs, exp);
  endtask

  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [14:0] q);
    logic [63:0] qq;
    logic [63:0] x;
    qq = {32'b0, q, 17'b0} | 64'd1;
    x  = ({32'b0, a} % qq) << 32;
    return 32'(x % qq);
  endfunction

  // One full operation: accept, wait for out_valid (bounded), check latency and result,
  // optionally hold out_ready low for bp cycles while poking in_valid, then hand off.
  task automatic run_op(input int s, input logic [31:0] a, input logic [14:0] q,
                        input logic [14:0] q_after, input logic [31:0] exp,
                        input int gap, input int bp, input string tag);
    int n;
    int lat;
    lat = (s == 0) ? 33 : 17;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    chk({tag, "_ready_before"}, s, in_ready_w[s], 1);
    a_d[s] = a;
    qh_d[s] = q;
    in_valid_d[s] = 1'b1;
    out_ready_d[s] = (bp == 0);
    @(negedge clk);
    in_valid_d[s] = 1'b0;
    a_d[s] = $urandom;
    qh_d[s] = q_after;
    n = 0;
    while (!out_valid_w[s] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, s, n, lat);
    chk({tag, "_result"}, s, t_w[s], exp);
    if (bp > 0) begin
      repeat (bp) begin
        in_valid_d[s] = 1'b1;
        a_d[s] = $urandom;
        @(negedge clk);
        chk({tag, "_bp_hold_t"}, s, t_w[s], exp);
        chk({tag, "_bp_in_ready"}, s, in_ready_w[s], 0);
        chk({tag, "_bp_out_valid"}, s, out_valid_w[s], 1);
      end
      in_valid_d[s] = 1'b0;
      out_ready_d[s] = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_ready_after"}, s, in_ready_w[s], 1);
    chk({tag, "_valid_after"}, s, out_valid_w[s], 0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [14:0] rq;
    for (int s = 0; s < 2; s++) begin
      rst_n_d[s] = 1'b0;
      in_valid_d[s] = 1'b0;
      out_ready_d[s] = 1'b1;
      a_d[s] = '0;
      qh_d[s] = 15'h4000;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_in_ready", s, in_ready_w[s], 1);
      chk("reset_out_valid", s, out_valid_w[s], 0);
      chk("reset_t", s, t_w[s], 0);
      chk("reset_state", s, st_w[s], 0);
    end
    rst_n_d[0] = 1'b1;
    rst_n_d[1] = 1'b1;

    for (int s = 0; s < 2; s++) begin
      // Q = 0x80000001, 2^32 mod Q = Q - 2
      run_op(s, 32'h0000_0001, 15'h4000, 15'h4000, 32'h7FFF_FFFF, 0, 0, "a1");
      run_op(s, 32'h0000_0002, 15'h4000, 15'h4000, 32'h7FFF_FFFD, 0, 0, "a2");
      run_op(s, 32'h0000_0000, 15'h4000, 15'h4000, 32'h0000_0000, 0, 0, "a0");
      run_op(s, 32'h8000_0001, 15'h4000, 15'h4000, 32'h0000_0000, 0, 0, "a_eq_q");
      // 0xFFFFFFFF = Q + (Q - 3) -> (-3)(-2) = 6
      run_op(s, 32'hFFFF_FFFF, 15'h4000, 15'h4000, 32'h0000_0006, 0, 0, "a_max");
      run_op(s, 32'h8000_0000, 15'h4000, 15'h4000, 32'h0000_0002, 0, 0, "a_qm1");
      run_op(s, 32'h7FFF_FFFF, 15'h4000, 15'h4000, 32'h0000_0004, 0, 0, "a_qm2");
      run_op(s, 32'h0000_0002, 15'h4000, 15'h4000, 32'h7FFF_FFFD, 1, 10, "bp");
      run_op(s, 32'h0000_0001, 15'h4000, 15'h5A3C, 32'h7FFF_FFFF, 0, 0, "qh_switch");
      qh_d[s] = 15'h4000;

      // Reset in the middle of ITER
      @(negedge clk);
      a_d[s] = 32'h0000_0005;
      in_valid_d[s] = 1'b1;
      @(negedge clk);
      in_valid_d[s] = 1'b0;
      repeat (11) @(negedge clk);
      chk("pre_reset_state_iter", s, st_w[s], 2);
      rst_n_d[s] = 1'b0;
      #1;
      chk("mid_reset_out_valid", s, out_valid_w[s], 0);
      chk("mid_reset_t", s, t_w[s], 0);
      chk("mid_reset_in_ready", s, in_ready_w[s], 1);
      repeat (2) @(negedge clk);
      chk("held_reset_state", s, st_w[s], 0);
      rst_n_d[s] = 1'b1;
      run_op(s, 32'h0000_0001, 15'h4000, 15'h4000, 32'h7FFF_FFFF, 0, 0, "after_reset");

      for (int i = 0; i < 40; i++) begin
        ra = $urandom;
        rq = 15'h4000 | 15'($urandom_range(0, 16'h3FFF));
        run_op(s, ra, rq, 15'($urandom), ref_model(ra, rq),
               $urandom_range(0, 3), $urandom_range(0, 2), "rand");
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
